// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: load-use, multicycle EX wait with timeout, EX branch redirect.
// Optional perf counters built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int unsigned MC_TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs1_use_i,
  input  logic        id_rs2_use_i,
  input  logic        id_rs1_F_i,
  input  logic        id_rs2_F_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_rd_wren_I_i,
  input  logic        ex_rd_wren_F_i,
  input  logic        ex_is_load_i,
  input  logic        ex_mc_i,
  input  logic        mc_done_i,
  input  logic        ex_br_taken_i,
  output logic        pc_en_o,
  output logic        if_id_en_o,
  output logic        id_ex_en_o,
  output logic        ex_mem_en_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        ex_mem_flush_o,
  output logic        mc_start_o,
  output logic        mc_abort_o,
  output logic        mc_err_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  typedef enum logic {RUN = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [7:0] TO_LAST = 8'(MC_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] to_cnt;
  logic       timeout, mc_wait, lu, rs1_hit, rs2_hit;

  // Same match rule as forwarding: x0/f0 never hazards, file must match.
  assign rs1_hit = id_rs1_use_i && (id_rs1_addr_i == ex_rd_addr_i) &&
                   (id_rs1_F_i ? ex_rd_wren_F_i : ex_rd_wren_I_i);
  assign rs2_hit = id_rs2_use_i && (id_rs2_addr_i == ex_rd_addr_i) &&
                   (id_rs2_F_i ? ex_rd_wren_F_i : ex_rd_wren_I_i);
  assign lu      = ex_is_load_i && (ex_rd_addr_i != 5'd0) && (rs1_hit || rs2_hit);

  assign timeout = (state == BUSY) && (to_cnt == TO_LAST);
  assign mc_wait = ((state == RUN)  && ex_mc_i && !mc_done_i) ||
                   ((state == BUSY) && !mc_done_i && !timeout);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (ex_mc_i && !mc_done_i)  state_nxt = BUSY;
      BUSY:    if (mc_done_i || timeout)   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    pc_en_o        = 1'b1;
    if_id_en_o     = 1'b1;
    id_ex_en_o     = 1'b1;
    ex_mem_en_o    = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    mc_start_o     = (state == RUN) && ex_mc_i;
    mc_abort_o     = timeout && !mc_done_i;
    if (mc_wait) begin
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      id_ex_en_o     = 1'b0;
      ex_mem_flush_o = 1'b1;
    end else if (ex_br_taken_i) begin
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
    end else if (lu) begin
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      id_ex_flush_o  = 1'b1;
    end
    if (rst_i) begin
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      id_ex_en_o     = 1'b0;
      ex_mem_en_o    = 1'b0;
      if_id_flush_o  = 1'b0;
      id_ex_flush_o  = 1'b0;
      ex_mem_flush_o = 1'b0;
      mc_start_o     = 1'b0;
      mc_abort_o     = 1'b0;
    end
  end

  // Counter is held at 0 outside BUSY, so it starts from 0 on BUSY entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt   <= 8'd0;
      mc_err_o <= 1'b0;
    end else begin
      to_cnt <= (state == BUSY) ? to_cnt + 8'd1 : 8'd0;
      if (mc_abort_o) mc_err_o <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= 32'd0;
      flush_cnt_o <= 32'd0;
    end else begin
      if (!pc_en_o)                      stall_cnt_o <= stall_cnt_o + 32'd1;
      if (if_id_flush_o || id_ex_flush_o) flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: single-cycle vector table plus multicycle/timeout/reset sequences.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1, rs2, rd;
  logic u1, u2, f1, f2, wi, wf, ld, mc, dn, br;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_fl, id_ex_fl, ex_mem_fl;
  logic mc_start, mc_abort, mc_err;
  logic [31:0] stall_cnt, flush_cnt;

  logic t_pc_en, t_if_id_en, t_id_ex_en, t_ex_mem_en, t_if_id_fl, t_id_ex_fl, t_ex_mem_fl;
  logic t_mc_start, t_mc_abort, t_mc_err;
  logic [31:0] t_stall_cnt, t_flush_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_rs1_use_i(u1), .id_rs2_use_i(u2),
    .id_rs1_F_i(f1), .id_rs2_F_i(f2), .ex_rd_addr_i(rd),
    .ex_rd_wren_I_i(wi), .ex_rd_wren_F_i(wf), .ex_is_load_i(ld),
    .ex_mc_i(mc), .mc_done_i(dn), .ex_br_taken_i(br),
    .pc_en_o(pc_en), .if_id_en_o(if_id_en), .id_ex_en_o(id_ex_en), .ex_mem_en_o(ex_mem_en),
    .if_id_flush_o(if_id_fl), .id_ex_flush_o(id_ex_fl), .ex_mem_flush_o(ex_mem_fl),
    .mc_start_o(mc_start), .mc_abort_o(mc_abort), .mc_err_o(mc_err),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  hazard_ctrl #(.MC_TIMEOUT(4)) dut_to (
    .clk_i(clk), .rst_i(rst),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_rs1_use_i(u1), .id_rs2_use_i(u2),
    .id_rs1_F_i(f1), .id_rs2_F_i(f2), .ex_rd_addr_i(rd),
    .ex_rd_wren_I_i(wi), .ex_rd_wren_F_i(wf), .ex_is_load_i(ld),
    .ex_mc_i(mc), .mc_done_i(dn), .ex_br_taken_i(br),
    .pc_en_o(t_pc_en), .if_id_en_o(t_if_id_en), .id_ex_en_o(t_id_ex_en), .ex_mem_en_o(t_ex_mem_en),
    .if_id_flush_o(t_if_id_fl), .id_ex_flush_o(t_id_ex_fl), .ex_mem_flush_o(t_ex_mem_fl),
    .mc_start_o(t_mc_start), .mc_abort_o(t_mc_abort), .mc_err_o(t_mc_err),
    .stall_cnt_o(t_stall_cnt), .flush_cnt_o(t_flush_cnt)
  );

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_fl, id_ex_fl, ex_mem_fl, start, abort}
  function automatic logic [8:0] outs();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_fl, id_ex_fl, ex_mem_fl, mc_start, mc_abort};
  endfunction

  function automatic logic [8:0] t_outs();
    return {t_pc_en, t_if_id_en, t_id_ex_en, t_ex_mem_en, t_if_id_fl, t_id_ex_fl, t_ex_mem_fl,
            t_mc_start, t_mc_abort};
  endfunction

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       u1, f1, u2, f2, wi, wf, ld, mc, dn, br;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(string nm, logic [4:0] a1, logic a1u, logic a1f,
                               logic [4:0] a2, logic a2u, logic a2f,
                               logic [4:0] d, logic dwi, logic dwf, logic dld,
                               logic m, logic md, logic b, logic [8:0] e);
    vec_t v;
    v.name = nm; v.rs1 = a1; v.u1 = a1u; v.f1 = a1f; v.rs2 = a2; v.u2 = a2u; v.f2 = a2f;
    v.rd = d; v.wi = dwi; v.wf = dwf; v.ld = dld; v.mc = m; v.dn = md; v.br = b; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; f1 = 0; f2 = 0;
    wi = 0; wf = 0; ld = 0; mc = 0; dn = 0; br = 0;
  endtask

  task automatic set_lu();
    ld = 1; rd = 5'd5; wi = 1; rs1 = 5'd5; u1 = 1;
  endtask

  task automatic pulse_rst();
    @(negedge clk); idle(); rst = 1; #2; rst = 0;
  endtask

  localparam logic [8:0] IDLE = 9'b1111_000_00;
  localparam logic [8:0] LU   = 9'b0011_010_00;
  localparam logic [8:0] BR   = 9'b1111_110_00;

  int stalls;

  initial begin
    rst = 1; idle();
    //    name          rs1 u f  rs2 u f  rd wi wf ld mc dn br exp
    addv("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
    addv("lu_rs1_x5",   5, 1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0, 0, LU);
    addv("lu_rs2_x5",   0, 0, 0, 5, 1, 0, 5, 1, 0, 1, 0, 0, 0, LU);
    addv("flw_f0",      0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, IDLE);
    addv("iload_fsrc",  5, 1, 1, 0, 0, 0, 5, 1, 0, 1, 0, 0, 0, IDLE);
    addv("no_use",      5, 0, 0, 5, 0, 0, 5, 1, 0, 1, 0, 0, 0, IDLE);
    addv("not_load",    5, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, IDLE);
    addv("lu_f7",       0, 0, 0, 7, 1, 1, 7, 0, 1, 1, 0, 0, 0, LU);
    addv("x0_iload",    0, 1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, IDLE);
    addv("branch",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, BR);
    addv("branch_lu",   5, 1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0, 1, BR);
    addv("mc_done_now", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 9'b1111_000_10);
    addv("mc_done_br",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 9'b1111_110_10);

    // Reset holds everything low even with live hazards on the inputs
    @(negedge clk); set_lu(); mc = 1; br = 1; #2;
    chk("rst_outs", outs(), 0);
    chk("rst_outs_to", t_outs(), 0);
    chk("rst_err", mc_err, 0);
    chk("rst_cnt", {stall_cnt, flush_cnt}, 0);
    @(negedge clk); rst = 0; idle(); #2;
    chk("post_rst_idle", outs(), IDLE);

    foreach (vecs[i]) begin
      @(negedge clk);
      rs1 = vecs[i].rs1; u1 = vecs[i].u1; f1 = vecs[i].f1;
      rs2 = vecs[i].rs2; u2 = vecs[i].u2; f2 = vecs[i].f2;
      rd = vecs[i].rd; wi = vecs[i].wi; wf = vecs[i].wf; ld = vecs[i].ld;
      mc = vecs[i].mc; dn = vecs[i].dn; br = vecs[i].br;
      #2;
      chk(vecs[i].name, outs(), vecs[i].exp);
    end

    // Load-use lasts one cycle once the ID instruction moves on
    @(negedge clk); idle(); set_lu(); #2; chk("lu_seq_stall", outs(), LU);
    @(negedge clk); idle(); #2; chk("lu_seq_release", outs(), IDLE);

    // 10-cycle multicycle op, then a back-to-back op done one cycle later
    pulse_rst();
    stalls = 0;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk); idle(); mc = 1; dn = (k == 10 || k == 12);
      if (k == 3) set_lu();
      if (k == 5) br = 1;
      #2;
      if (k <= 10) stalls += (pc_en ? 0 : 1);
      chk($sformatf("mc_pc_en_k%0d", k), pc_en, (k == 10 || k == 12));
      chk($sformatf("mc_exm_fl_k%0d", k), ex_mem_fl, (k < 10 || k == 11));
      chk($sformatf("mc_start_k%0d", k), mc_start, (k == 0 || k == 11));
      chk($sformatf("mc_flush_k%0d", k), {if_id_fl, id_ex_fl}, 0);
      chk($sformatf("mc_abort_k%0d", k), mc_abort, 0);
    end
    chk("mc_stall_cycles", stalls, 10);
    @(negedge clk); idle(); #2; chk("mc_release", outs(), IDLE);

    // Timeout with MC_TIMEOUT=4: abort on 4th BUSY cycle (k=4)
    pulse_rst();
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk); idle(); mc = (k <= 4); dn = (k == 5); #2;
      chk($sformatf("to_abort_k%0d", k), t_mc_abort, (k == 4));
      chk($sformatf("to_pc_en_k%0d", k), t_pc_en, (k >= 4));
      chk($sformatf("to_err_k%0d", k), t_mc_err, (k == 5));
      if (k == 4) chk("to_main_still_busy", {pc_en, mc_abort}, 2'b00);
    end
    @(negedge clk); idle(); #2; chk("to_err_sticky", t_mc_err, 1);

    // Reset asserted mid-BUSY
    @(negedge clk); idle(); mc = 1; #2;
    @(negedge clk); #2; chk("busy_before_rst", {pc_en, mc_start}, 2'b00);
    rst = 1; #1;
    chk("mid_rst_outs", outs(), 0);
    chk("mid_rst_err", t_mc_err, 0);
    rst = 0; #1;
    chk("after_rst_run_start", {pc_en, mc_start}, 2'b01);
    @(negedge clk); idle(); dn = 1; #2; chk("after_rst_release", outs(), IDLE);

    // Done coinciding with timeout counts as done
    pulse_rst();
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk); idle(); mc = 1; dn = (k == 4); #2;
    end
    chk("done_to_abort", {t_mc_abort, t_pc_en}, 2'b01);
    @(negedge clk); idle(); #2; chk("done_to_err", t_mc_err, 0);

    // Perf counters: 1 load-use, 1 branch, 3-cycle multicycle stall
    pulse_rst();
    @(negedge clk); idle(); set_lu(); #2;
    @(negedge clk); idle(); br = 1; #2;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk); idle(); mc = 1; dn = (k == 3); #2;
    end
    @(negedge clk); idle(); #2;
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, 4);
    chk("flush_cnt", flush_cnt, 2);
    rst = 1; #1;
    chk("cnt_rst", {stall_cnt, flush_cnt}, 0);
    rst = 0;
`else
    chk("stall_cnt_tied", stall_cnt, 0);
    chk("flush_cnt_tied", flush_cnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline stall/flush controller for the five-stage RISC-V core with separate integer (I) and float (F) register files. It sits upstream of the EX operand-forwarding logic and drives the enables and flushes of the PC and the IF/ID, ID/EX and EX/MEM registers. Its job is to make sure the instruction pair that reaches forwarding is always resolvable by forwarding. It handles three cases: load-use hazards, multicycle EX operations (FP divide/sqrt, integer divide) with a timeout guard, and branch redirects resolved in EX.

## Interface
- MC_TIMEOUT, default 64: maximum number of BUSY cycles to wait for `mc_done_i` before a forced abort; legal range 2..255.
- `clk_i` input 1: clock; rising edge.
- `rst_i` input 1: reset; asynchronous, active-high.
- `id_rs1_addr_i`, `id_rs2_addr_i` input 5: source register addresses of the instruction in ID.
- `id_rs1_use_i`, `id_rs2_use_i` input 1: the ID instruction actually reads rs1 / rs2.
- `id_rs1_F_i`, `id_rs2_F_i` input 1: 1 means the source is read from the F file, 0 means the I file.
- `ex_rd_addr_i` input 5: destination register of the instruction in EX.
- `ex_rd_wren_I_i`, `ex_rd_wren_F_i` input 1: the EX instruction writes the I / F file.
- `ex_is_load_i` input 1: the EX instruction is a load.
- `ex_mc_i` input 1: the EX instruction is a multicycle op (level signal).
- `mc_done_i` input 1: the multicycle unit's result is valid this cycle (pulse).
- `ex_br_taken_i` input 1: a taken branch or jump is resolved in EX.
- `pc_en_o`, `if_id_en_o`, `id_ex_en_o`, `ex_mem_en_o` output 1: register enables.
- `if_id_flush_o`, `id_ex_flush_o`, `ex_mem_flush_o` output 1: insert a bubble at the next edge.
- `mc_start_o` output 1: one-cycle start pulse to the multicycle unit.
- `mc_abort_o` output 1: one-cycle pulse indicating a timeout abort.
- `mc_err_o` output 1: sticky timeout flag; cleared only by reset.
- `stall_cnt_o`, `flush_cnt_o` output 32: performance counters (see Configuration).

## Operation
- Load-use hazard (`lu`): all of the following hold.
  - `ex_is_load_i` = 1.
  - `ex_rd_addr_i` != 0.
  - For rs1 or rs2: `use`=1, the address equals `ex_rd_addr_i`, and the file matches (F source with `ex_rd_wren_F_i`, I source with `ex_rd_wren_I_i`).
  - Address 0 never hazards in either file. This is the same rule forwarding applies.
- FSM states:
  - RUN → BUSY when `ex_mc_i`=1 and `mc_done_i`=0.
  - BUSY → RUN on `mc_done_i`=1, or when the timeout counter reaches MC_TIMEOUT-1.
- `mc_start_o` = 1 only in RUN with `ex_mc_i`=1. It does not fire in BUSY.
- `mc_wait` = (RUN and `ex_mc_i` and !`mc_done_i`) or (BUSY and !`mc_done_i` and !timeout).
- While `mc_wait` = 1:
  - `pc_en_o`, `if_id_en_o`, `id_ex_en_o` = 0.
  - `ex_mem_flush_o` = 1.
  - `lu` and `ex_br_taken_i` are ignored.
- Timeout: the 8-bit counter clears on entry to BUSY and increments each cycle spent in BUSY. On a timeout:
  - `mc_abort_o` = 1 for that cycle and `mc_err_o` is set.
  - The pipeline is released as if `mc_done_i` had arrived.
- Else if `ex_br_taken_i` = 1: `if_id_flush_o` = 1 and `id_ex_flush_o` = 1, with all enables at 1. Branch beats `lu`.
- Else if `lu` = 1: `pc_en_o` = 0, `if_id_en_o` = 0, `id_ex_flush_o` = 1, for exactly one cycle.
- Otherwise all enables are 1 and all flushes are 0. `ex_mem_en_o` is always 1.

## Timing
- All outputs are combinational from the registered state plus the current inputs. State, counter and `mc_err_o` update on the rising edge.
- Load-use costs 1 bubble.
- A multicycle op completing N cycles after it enters EX stalls N cycles. If `mc_done_i` arrives in the same cycle the op enters EX, there is no stall and no BUSY entry.
- Back-to-back multicycle ops: the done cycle releases the pipeline. The next op in EX then pulses `mc_start_o` from RUN in the following cycle.
- While `rst_i` = 1:
  - State = RUN, counter = 0, `mc_err_o` = 0.
  - All `*_en_o` = 0, all `*_flush_o` = 0.
  - `mc_start_o` = `mc_abort_o` = 0.
  - Counters = 0.
- Reset asserted mid-BUSY returns to RUN immediately (asynchronous).
- `mc_done_i` and timeout in the same cycle: treated as done, with no abort and no error.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cnt_o` increments on every cycle with `pc_en_o` = 0.
  - `flush_cnt_o` increments on every cycle with `if_id_flush_o` or `id_ex_flush_o` = 1.
  - Both counters wrap at 2^32 and are reset by `rst_i`.
- `HAZARD_PERF_CNT_EN` not defined: both ports remain and are tied to 0, and no counter flops are built.

## Test plan
- Load-use case 1: EX load x5 (I file) with ID add reading x5. Required: one cycle of `pc_en_o`=0, `if_id_en_o`=0, `id_ex_flush_o`=1, then normal flow.
- Load-use case 2: EX `flw` f0 with an ID F source f0 gives no stall. An EX I-file load x5 with ID reading F-file f5 also gives no stall.
- Multicycle: `ex_mc_i`=1 with `mc_done_i` arriving on the 10th cycle. Required: `mc_start_o` pulses once, `pc_en_o`=0 for exactly 10 cycles, `ex_mem_flush_o`=1 for those 10 cycles, then release.
- Timeout: MC_TIMEOUT=4 and `mc_done_i` never asserts. Required: `mc_abort_o` pulses on the 4th BUSY cycle, `mc_err_o` latches at 1, and the pipeline releases.
- Priority: `ex_br_taken_i`=1 together with `lu`=1 gives both flushes and no stall. `ex_br_taken_i` raised during BUSY is ignored.
- With `HAZARD_PERF_CNT_EN`: the sequence of 1 load-use, 1 branch and a 3-cycle multicycle stall ends with `stall_cnt_o`=4 and `flush_cnt_o`=2. Asserting `rst_i` mid-BUSY clears all state.
